rle_decompress_engine: RTL and testbench
========================================

# rle_decompress_engine

Run-length decode engine on the responder side of the frame-buffer decompress handshake. On a one-cycle `decompress_start` pulse it reads compressed words from the compressed-frame SPRAM, expands each run into pixel writes toward the display frame buffer, and returns a one-cycle `decompress_finish` pulse once a full frame has been written. It sits between the compress/decompress control logic and the frame-buffer write port.

## Interface
Parameters:
- `ADDR_W`, 14: width of compressed-memory and pixel addresses.
- `FRAME_PIXELS`, 16384: pixels per frame, 1..2^ADDR_W.

Ports:
- `clock`  in  1  single clock for the block.
- `reset`  in  1  synchronous, active-high reset.
- `decompress_start`  in  1  one-cycle start pulse.
- `decompress_finish`  out  1  one-cycle pulse when the frame is complete.
- `busy`  out  1  high while a decode is in progress.
- `rd_en`  out  1  compressed-memory read strobe.
- `rd_addr`  out  ADDR_W  compressed-memory word address.
- `rd_data`  in  16  compressed word, valid exactly 1 cycle after `rd_en`.
- `pix_valid`  out  1  pixel write request.
- `pix_ready`  in  1  frame-buffer accept.
- `pix_addr`  out  ADDR_W  pixel address.
- `pix_data`  out  8  pixel value.
- `err_overrun`  out  1  sticky error flag: the last run exceeded the frame.

## Operation
- Word format: `[15:8]` holds run length minus 1, covering 1..256 pixels; `[7:0]` holds the pixel value.
- State machine: IDLE -> FETCH -> LOAD -> RUN, then either back to FETCH or to IDLE.
  - IDLE: a start pulse sets `rd_en`=1, `rd_addr`=0, `pix_addr`=0 and `busy`=1, then moves to FETCH.
  - FETCH: drives `rd_en`=0 and moves to LOAD.
  - LOAD: latches `rd_data`, loads the run counter from `[15:8]` and `pix_data` from `[7:0]`, sets `pix_valid`=1, then moves to RUN.
  - RUN: a transfer occurs when `pix_valid & pix_ready`. Each transfer increments `pix_addr` and decrements the run counter.
    - Last pixel of the run, frame not complete: `pix_valid`=0, `rd_en`=1, `rd_addr`+1, go to FETCH.
    - Frame complete: `pix_valid`=0, `busy`=0, `decompress_finish`=1, go to IDLE.
- Frame completion is reached when the transfer at `pix_addr` = FRAME_PIXELS-1 occurs.
  - If the run counter is not exhausted at that point, the remainder is discarded (truncation) and the overrun condition applies.
- `rd_addr` wraps modulo 2^ADDR_W. `pix_addr` never exceeds FRAME_PIXELS-1.
- A start pulse received in any state other than IDLE is ignored. A start pulse in the same cycle that `decompress_finish` is high is accepted.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Reset mid-operation: the block returns to IDLE at the next edge and no further pixel or read is issued.
- Cycle numbering uses the start edge as E0:
  - `rd_en` is high between E0 and E1.
  - The first `pix_valid` is high after E2.
- Gap between runs: 2 cycles with `pix_valid` low after the last transfer of a run.
- `decompress_finish` is high for exactly the one cycle following the final transfer edge.
- Backpressure: while `pix_valid` is high and `pix_ready` is low, `pix_addr` and `pix_data` hold stable.
- `rd_en` is never asserted while `pix_valid` is high.

## Configuration
- `RLE_OVERRUN_CHECK_EN` defined:
  - `err_overrun` is set when frame completion occurs with run pixels remaining.
  - It stays set until the next accepted start pulse clears it.
- `RLE_OVERRUN_CHECK_EN` undefined:
  - `err_overrun` is tied to 0.
  - Truncation behaviour is identical in both builds.

## Test plan
- Reset: assert `reset` for 2 cycles mid-run (FRAME_PIXELS=8) -> all outputs 0 the next cycle; no pixel after release.
- Basic decode: FRAME_PIXELS=8, memory {0x03AA, 0x0355}, `pix_ready`=1, start at E0.
  - Pixels 0xAA at addresses 0-3 transfer at E3-E6.
  - Pixels 0x55 at addresses 4-7 transfer at E9-E12.
  - `decompress_finish` is high for one cycle after E12; `err_overrun`=0.
- Backpressure: same memory, with `pix_ready` low for 3 cycles at `pix_addr`=2 -> `pix_addr`/`pix_data` held at 2/0xAA; exactly 8 transfers; finish 3 cycles later than in the basic decode.
- Overrun: FRAME_PIXELS=8, memory {0x0A11}.
  - 8 pixels of 0x11 at addresses 0-7, then the finish pulse, then `err_overrun`=1 (macro defined) or 0 (macro undefined).
  - The next start clears `err_overrun`.
- Maximum run: FRAME_PIXELS=256, memory {0xFF3C} -> 256 pixels of 0x3C at addresses 0-255, a single `rd_en`, finish pulse, no overrun.
- Start while busy: a second start pulse at E5 of the basic decode -> ignored, output identical to the basic decode; a start pulse in the finish cycle triggers a new frame with `rd_en` one cycle later.

Source files
------------

// File: rtl/rle_decompress_engine.sv
// Run-length decode engine: expands 16-bit {len-1, value} words into frame-buffer pixel writes.
// Optional sticky overrun flag is compiled in with `define RLE_OVERRUN_CHECK_EN.
module rle_decompress_engine #(
  parameter int ADDR_W       = 14,
  parameter int FRAME_PIXELS = 16384
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              decompress_start,
  output logic              decompress_finish,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              err_overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state, state_d;
  logic              rd_en_d, pix_valid_d, busy_d, finish_d;
  logic [ADDR_W-1:0] rd_addr_d, pix_addr_d;
  logic [7:0]        pix_data_d;
  logic [7:0]        run_cnt, run_cnt_d;

  // Pixel handshake: a pixel moves on a clock edge where pix_valid & pix_ready;
  // once pix_valid rises, pix_addr/pix_data hold until that edge.
  always_comb begin
    state_d     = state;
    rd_en_d     = rd_en;
    rd_addr_d   = rd_addr;
    pix_valid_d = pix_valid;
    pix_addr_d  = pix_addr;
    pix_data_d  = pix_data;
    run_cnt_d   = run_cnt;
    busy_d      = busy;
    finish_d    = 1'b0;
    case (state)
      IDLE: begin
        if (decompress_start) begin
          state_d    = FETCH;
          rd_en_d    = 1'b1;
          rd_addr_d  = '0;
          pix_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      FETCH: begin
        rd_en_d = 1'b0;
        state_d = LOAD;
      end
      LOAD: begin
        run_cnt_d   = rd_data[15:8];
        pix_data_d  = rd_data[7:0];
        pix_valid_d = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (pix_valid && pix_ready) begin
          run_cnt_d = run_cnt - 8'd1;
          if (pix_addr == LAST_PIX) begin
            // Frame full: any remaining run pixels are dropped.
            pix_valid_d = 1'b0;
            busy_d      = 1'b0;
            finish_d    = 1'b1;
            state_d     = IDLE;
          end else begin
            pix_addr_d = pix_addr + ONE;
            if (run_cnt == 8'd0) begin
              pix_valid_d = 1'b0;
              rd_en_d     = 1'b1;
              rd_addr_d   = rd_addr + ONE;
              state_d     = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      rd_en             <= 1'b0;
      rd_addr           <= '0;
      pix_valid         <= 1'b0;
      pix_addr          <= '0;
      pix_data          <= '0;
      run_cnt           <= '0;
      busy              <= 1'b0;
      decompress_finish <= 1'b0;
    end else begin
      state             <= state_d;
      rd_en             <= rd_en_d;
      rd_addr           <= rd_addr_d;
      pix_valid         <= pix_valid_d;
      pix_addr          <= pix_addr_d;
      pix_data          <= pix_data_d;
      run_cnt           <= run_cnt_d;
      busy              <= busy_d;
      decompress_finish <= finish_d;
    end
  end

`ifdef RLE_OVERRUN_CHECK_EN
  logic accept_start, overrun_evt, err_q;
  assign accept_start = (state == IDLE) && decompress_start;
  assign overrun_evt  = (state == RUN) && pix_valid && pix_ready &&
                        (pix_addr == LAST_PIX) && (run_cnt != 8'd0);

  always_ff @(posedge clock) begin
    if (reset)             err_q <= 1'b0;
    else if (accept_start) err_q <= 1'b0;
    else if (overrun_evt)  err_q <= 1'b1;
  end
  assign err_overrun = err_q;
`else
  assign err_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_rle_decompress_engine.sv
// Directed bench for rle_decompress_engine: a vector table of frames (8- and 256-pixel builds)
// plus hand-written reset, start-while-busy and start-in-finish-cycle sequences.
module tb_rle_decompress_engine;
  localparam int AW = 14;
`ifdef RLE_OVERRUN_CHECK_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic sel, decompress_start, pix_ready;
  logic start_a, start_b;
  logic fin_a, busy_a, rd_en_a, pv_a, err_a, fin_b, busy_b, rd_en_b, pv_b, err_b;
  logic [AW-1:0] rd_addr_a, pa_a, rd_addr_b, pa_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [7:0] pd_a, pd_b;
  logic [15:0] mem_a[4];
  logic [15:0] mem_b[4];

  assign start_a = decompress_start & ~sel;
  assign start_b = decompress_start & sel;

  rle_decompress_engine #(.ADDR_W(AW), .FRAME_PIXELS(8)) dut_a (
    .clock(clock), .reset(reset), .decompress_start(start_a), .decompress_finish(fin_a),
    .busy(busy_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .pix_valid(pv_a), .pix_ready(pix_ready), .pix_addr(pa_a), .pix_data(pd_a),
    .err_overrun(err_a));

  rle_decompress_engine #(.ADDR_W(AW), .FRAME_PIXELS(256)) dut_b (
    .clock(clock), .reset(reset), .decompress_start(start_b), .decompress_finish(fin_b),
    .busy(busy_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .pix_valid(pv_b), .pix_ready(pix_ready), .pix_addr(pa_b), .pix_data(pd_b),
    .err_overrun(err_b));

  // Compressed-frame SPRAM models: one-cycle read latency.
  always @(posedge clock) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a[1:0]];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b[1:0]];
  end

  logic          decompress_finish, busy, rd_en, pix_valid, err_overrun;
  logic [AW-1:0] rd_addr, pix_addr;
  logic [7:0]    pix_data;
  assign decompress_finish = sel ? fin_b : fin_a;
  assign busy        = sel ? busy_b : busy_a;
  assign rd_en       = sel ? rd_en_b : rd_en_a;
  assign rd_addr     = sel ? rd_addr_b : rd_addr_a;
  assign pix_valid   = sel ? pv_b : pv_a;
  assign pix_addr    = sel ? pa_b : pa_a;
  assign pix_data    = sel ? pd_b : pd_a;
  assign err_overrun = sel ? err_b : err_a;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          nw;
    bit          big;
    int          stall_addr;
    int          extra_start_k;
    bit          chain;
    int          exp_fin_k;
    int          exp_reads;
    bit          exp_ovr;
  } vec_t;

  vec_t vecs[6];
  logic [AW+7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int idx, input bit skip_start);
    vec_t v;
    int fp, addr, stall_left, fin_k, reads;
    logic [15:0] word;
    logic [AW+7:0] e;
    v = vecs[idx];
    sel = v.big;
    fp = v.big ? 256 : 8;
    if (v.big) mem_b[0] = v.w0;
    else begin
      mem_a[0] = v.w0;
      mem_a[1] = v.w1;
    end
    addr = 0;
    for (int w = 0; w < v.nw; w++) begin
      word = (w == 0) ? v.w0 : v.w1;
      for (int i = 0; i <= int'(word[15:8]); i++) begin
        if (addr < fp) exp_q.push_back({AW'(addr), word[7:0]});
        addr++;
      end
    end
    if (!skip_start) begin
      @(negedge clock);
      decompress_start = 1'b1;
    end
    @(posedge clock);
    fin_k = -1;
    reads = 0;
    stall_left = (v.stall_addr >= 0) ? 3 : 0;
    for (int k = 0; k < 400 && fin_k < 0; k++) begin
      @(negedge clock);
      decompress_start = (k + 1 == v.extra_start_k);
      pix_ready = 1'b1;
      if (k == 0) begin
        check("start_rd_en", rd_en, 1);
        check("start_rd_addr", rd_addr, 0);
        check("start_busy", busy, 1);
        check("start_finish_low", decompress_finish, 0);
        check("start_err_cleared", err_overrun, 0);
      end
      if (rd_en) reads++;
      check("rd_en_with_pix_valid", rd_en & pix_valid, 0);
      if (pix_valid && stall_left > 0 && pix_addr == AW'(v.stall_addr)) begin
        pix_ready = 1'b0;
        stall_left--;
        check("stall_hold_addr", pix_addr, AW'(v.stall_addr));
        if (exp_q.size() > 0) check("stall_hold_data", pix_data, exp_q[0][7:0]);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) check("extra_pixel", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pixel_addr_data", {pix_addr, pix_data}, e);
        end
      end
      if (decompress_finish) begin
        fin_k = k;
        if (v.chain) decompress_start = 1'b1;
      end
    end
    check("finish_cycle", fin_k, v.exp_fin_k);
    check("pixels_missing", exp_q.size(), 0);
    exp_q.delete();
    check("read_count", reads, v.exp_reads);
    if (fin_k >= 0) begin
      check("finish_busy_low", busy, 0);
      check("finish_pix_valid_low", pix_valid, 0);
      check("finish_err_overrun", err_overrun, v.exp_ovr);
    end
    if (!v.chain) begin
      @(negedge clock);
      check("finish_one_cycle", decompress_finish, 0);
      check("idle_busy", busy, 0);
      check("idle_err_overrun", err_overrun, v.exp_ovr);
    end
  endtask

  initial begin
    int bad_pix, bad_rd;
    sel = 1'b0;
    decompress_start = 1'b0;
    pix_ready = 1'b1;
    //           w0       w1       nw big stall extra chain fin reads ovr
    vecs[0] = '{16'h03AA, 16'h0355, 2, 0, -1, -1, 0, 12,  2, 0};
    vecs[1] = '{16'h03AA, 16'h0355, 2, 0,  2, -1, 0, 15,  2, 0};
    vecs[2] = '{16'h0A11, 16'h0000, 1, 0, -1, -1, 0, 10,  1, OVR};
    vecs[3] = '{16'h03AA, 16'h0355, 2, 0, -1, -1, 1, 12,  2, 0};
    vecs[4] = '{16'h03AA, 16'h0355, 2, 0, -1,  5, 0, 12,  2, 0};
    vecs[5] = '{16'hFF3C, 16'h0000, 1, 1, -1, -1, 0, 258, 1, 0};

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_rd_en", rd_en, 0);
    check("reset_busy", busy, 0);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_finish", decompress_finish, 0);
    check("reset_pix_addr", pix_addr, 0);
    check("reset_err", err_overrun, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(i, (i > 0) ? vecs[i-1].chain : 1'b0);

    // Reset in the middle of the first run of the basic frame.
    sel = 1'b0;
    mem_a[0] = 16'h03AA;
    mem_a[1] = 16'h0355;
    @(negedge clock);
    decompress_start = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      decompress_start = 1'b0;
    end
    check("pre_reset_pix_valid", pix_valid, 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midreset_outputs",
          {rd_en, busy, pix_valid, decompress_finish, err_overrun, rd_addr, pix_addr, pix_data},
          0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bad_pix = 0;
    bad_rd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (pix_valid) bad_pix++;
      if (rd_en || busy || decompress_finish) bad_rd++;
    end
    check("post_reset_no_pixels", bad_pix, 0);
    check("post_reset_quiet", bad_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
